// File: rtl/cesa_pkg.sv
// Shared types and carry-estimate helpers for the carry-estimating adder.
// Optional exact-result recovery is enabled with CESA_RECOVERY_EN.
package cesa_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OUT  = 2'd1,
        FIX  = 2'd2
    } state_e;

    function automatic logic maj3(
        input logic x,
        input logic y,
        input logic z
    );
        return (x & y) | (x & z) | (y & z);
    endfunction

    // a/b hold the top four bits of the segment below, msb first
    function automatic logic est_carry(
        input logic [3:0] a,
        input logic [3:0] b
    );
        logic sel;
        sel = (a[3] ^ b[3]) & (a[2] ^ b[2]);
        return sel ? maj3(a[1], b[1], a[0] & b[0])
                   : maj3(a[3], b[3], a[2] & b[2]);
    endfunction

endpackage

// File: rtl/cesa_segment.sv
// One BLK-bit ripple slice: speculative sum, carry-out, group P/G and
// the carry estimate handed to the next segment up.
module cesa_segment
    import cesa_pkg::*;
#(
    parameter int BLK = 8
) (
    input  logic [BLK-1:0] a,
    input  logic [BLK-1:0] b,
    input  logic           cin,
    output logic [BLK-1:0] sum,
    output logic           cout,
    output logic           prop,
    output logic           gen,
    output logic           est
);

    always_comb begin : ripple
        logic c;
        logic gc;
        sum  = '0;
        c    = cin;
        gc   = 1'b0;
        for (int i = 0; i < BLK; i++) begin
            sum[i] = a[i] ^ b[i] ^ c;
            c      = (a[i] & b[i]) | ((a[i] ^ b[i]) & c);
            gc     = (a[i] & b[i]) | ((a[i] ^ b[i]) & gc);
        end
        cout = c;
        gen  = gc;
    end

    assign prop = &(a ^ b);
    assign est  = est_carry(a[BLK-1 -: 4], b[BLK-1 -: 4]);

endmodule

// File: rtl/cesa_adder_pipe.sv
// Registered carry-estimating speculative adder with valid/ready output.
// Define CESA_RECOVERY_EN to add the one-cycle exact-result FIX state.
module cesa_adder_pipe
    import cesa_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int BLK   = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o,
    output logic             spec_err_o
);

    localparam int NSEG = WIDTH / BLK;

    logic [WIDTH-1:0] spec_sum;
    logic [NSEG:0]    est_c;
    logic [NSEG-1:0]  seg_co;
    logic [NSEG-1:0]  seg_p;
    logic [NSEG-1:0]  seg_g;

    assign est_c[0] = cin_i;

    for (genvar k = 0; k < NSEG; k++) begin : g_seg
        cesa_segment #(.BLK(BLK)) u_seg (
            .a    (a_i[k*BLK +: BLK]),
            .b    (b_i[k*BLK +: BLK]),
            .cin  (est_c[k]),
            .sum  (spec_sum[k*BLK +: BLK]),
            .cout (seg_co[k]),
            .prop (seg_p[k]),
            .gen  (seg_g[k]),
            .est  (est_c[k+1])
        );
    end

    state_e           state;
    state_e           cur;
    logic [WIDTH-1:0] sum_r;
    logic             cout_r;
    logic [NSEG:0]    est_r;
    logic [NSEG-1:0]  co_r;
    logic [NSEG-1:0]  p_r;
    logic [NSEG-1:0]  g_r;
    logic [NSEG:0]    exact;
    logic             mismatch;
    logic             cap;

    // A segment whose estimate held already knows its exact carry-out
    always_comb begin
        exact    = '0;
        exact[0] = est_r[0];
        for (int k = 0; k < NSEG; k++) begin
            exact[k+1] = (exact[k] == est_r[k]) ? co_r[k]
                       : (g_r[k] | (p_r[k] & exact[k]));
        end
    end

    assign mismatch = |(est_r[NSEG:1] ^ exact[NSEG:1]);

`ifdef CESA_RECOVERY_EN
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] fix_sum;
    logic             fixed_r;

    always_comb begin
        fix_sum = '0;
        for (int k = 0; k < NSEG; k++) begin
            fix_sum[k*BLK +: BLK] = a_r[k*BLK +: BLK]
                                  + b_r[k*BLK +: BLK]
                                  + BLK'(exact[k]);
        end
    end

    // The cycle a mismatch is first seen already counts as FIX
    assign cur = (state == OUT && mismatch && !fixed_r) ? FIX : state;
    assign out_valid_o = (cur == OUT);
    assign spec_err_o  = (cur == OUT) & fixed_r;
`else
    assign cur         = state;
    assign out_valid_o = (state == OUT);
    assign spec_err_o  = (state == OUT) & mismatch;
`endif

    assign in_ready_o = (cur == IDLE)
                      | ((cur == OUT) & out_ready_i & out_valid_o);
    assign cap    = in_valid_i & in_ready_o;
    assign sum_o  = sum_r;
    assign cout_o = cout_r;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state  <= IDLE;
            sum_r  <= '0;
            cout_r <= 1'b0;
            est_r  <= '0;
            co_r   <= '0;
            p_r    <= '0;
            g_r    <= '0;
`ifdef CESA_RECOVERY_EN
            a_r     <= '0;
            b_r     <= '0;
            fixed_r <= 1'b0;
`endif
        end else if (cap) begin
            state  <= OUT;
            sum_r  <= spec_sum;
            cout_r <= est_c[NSEG];
            est_r  <= est_c;
            co_r   <= seg_co;
            p_r    <= seg_p;
            g_r    <= seg_g;
`ifdef CESA_RECOVERY_EN
            a_r     <= a_i;
            b_r     <= b_i;
            fixed_r <= 1'b0;
`endif
        end else begin
            unique case (cur)
                IDLE: state <= IDLE;
                OUT: begin
                    if (out_ready_i) begin
                        state <= IDLE;
                    end
                end
                FIX: begin
`ifdef CESA_RECOVERY_EN
                    sum_r   <= fix_sum;
                    cout_r  <= exact[NSEG];
                    fixed_r <= 1'b1;
                    state   <= OUT;
`else
                    state   <= IDLE;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cesa_adder_pipe.sv
// Directed bench for cesa_adder_pipe with an arithmetic reference model.
// Honours CESA_RECOVERY_EN to select exact or speculative expectations.
module tb_cesa_adder_pipe;

    localparam int WIDTH = 32;
    localparam int BLK   = 8;
    localparam int NSEG  = WIDTH / BLK;

    logic             clk = 1'b0;
    logic             rst_ni = 1'b0;
    logic             in_valid_i = 1'b0;
    logic             in_ready_o;
    logic [WIDTH-1:0] a_i = '0;
    logic [WIDTH-1:0] b_i = '0;
    logic             cin_i = 1'b0;
    logic             out_valid_o;
    logic             out_ready_i = 1'b1;
    logic [WIDTH-1:0] sum_o;
    logic             cout_o;
    logic             spec_err_o;

    cesa_adder_pipe #(.WIDTH(WIDTH), .BLK(BLK)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .a_i         (a_i),
        .b_i         (b_i),
        .cin_i       (cin_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .sum_o       (sum_o),
        .cout_o      (cout_o),
        .spec_err_o  (spec_err_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] s;
        logic        co;
        logic        err;
        int          lat;
        int          due;
        bit          shown;
    } exp_t;

    exp_t q[$];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    function automatic bit est_bit(input logic [31:0] a,
                                   input logic [31:0] b, input int t);
        int x, y, z, w, p, r;
        x = int'(a[t]);   y = int'(b[t]);
        z = int'(a[t-1]); w = int'(b[t-1]);
        p = int'(a[t-2]) + int'(b[t-2]);
        r = int'(a[t-3] & b[t-3]);
        if (((x ^ y) & (z ^ w)) != 0) return (p + r) >= 2;
        return (x + y + (z & w)) >= 2;
    endfunction

    task automatic model(input logic [31:0] a, input logic [31:0] b,
                         input logic c, output exp_t e);
        logic [63:0] ex, m, lm, seg, ek;
        logic [31:0] spec;
        bit          est, err;
        int          lo;
        ex   = {32'd0, a} + {32'd0, b} + {63'd0, c};
        est  = c;
        err  = 1'b0;
        spec = '0;
        for (int k = 0; k < NSEG; k++) begin
            lo   = k * BLK;
            m    = (64'd1 << BLK) - 1;
            seg  = (({32'd0, a} >> lo) & m) + (({32'd0, b} >> lo) & m)
                 + {63'd0, est};
            spec = spec | 32'((seg & m) << lo);
            lm   = (64'd1 << (lo + BLK)) - 1;
            ek   = (({32'd0, a} & lm) + ({32'd0, b} & lm) + {63'd0, c})
                 >> (lo + BLK);
            est  = est_bit(a, b, lo + BLK - 1);
            if (est != ek[0]) err = 1'b1;
        end
        e.err   = err;
        e.shown = 1'b0;
        e.due   = 0;
`ifdef CESA_RECOVERY_EN
        e.s   = ex[31:0];
        e.co  = ex[32];
        e.lat = err ? 2 : 1;
`else
        e.s   = spec;
        e.co  = est;
        e.lat = 1;
`endif
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst_ni) begin
            q.delete();
        end else begin
            if (out_valid_o) begin
                if (q.size() == 0) begin
                    chk("unexpected_valid", {63'd0, out_valid_o}, 64'd0);
                end else begin
                    if (!q[0].shown) begin
                        chk("latency", cyc, q[0].due);
                        q[0].shown = 1'b1;
                    end
                    chk("mon_sum", {32'd0, sum_o}, {32'd0, q[0].s});
                    chk("mon_cout", {63'd0, cout_o}, {63'd0, q[0].co});
                    chk("mon_err", {63'd0, spec_err_o}, {63'd0, q[0].err});
                    if (out_ready_i) void'(q.pop_front());
                end
            end
            if (in_valid_i && in_ready_o) begin
                model(a_i, b_i, cin_i, e);
                e.due = cyc + e.lat;
                q.push_back(e);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b,
                        input logic c);
        bit ok;
        int n;
        ok = 1'b0;
        n  = 0;
        in_valid_i = 1'b1;
        a_i   = a;
        b_i   = b;
        cin_i = c;
        while (!ok && n < 20) begin
            if (in_ready_o) begin
                @(posedge clk);
                #1;
                ok = 1'b1;
            end else begin
                @(negedge clk);
                n++;
            end
        end
        in_valid_i = 1'b0;
        if (!ok) chk("send_timeout", 64'd0, 64'd1);
    endtask

    logic [31:0] va [5] = '{32'h0F0F0F0F, 32'h80000000, 32'h7FFFFFFF,
                            32'h12345678, 32'hC0C0C0C0};
    logic [31:0] vb [5] = '{32'h01010101, 32'h80000000, 32'h00000001,
                            32'h87654321, 32'h40404040};
    logic        vc [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

    initial begin
        exp_t e;

        model(32'h1, 32'h2, 1'b0, e);
        chk("pin_small_sum", {32'd0, e.s}, 64'h3);
        chk("pin_small_err", {63'd0, e.err}, 64'd0);
        model(32'hFF, 32'h1, 1'b0, e);
        chk("pin_ff_err", {63'd0, e.err}, 64'd1);
`ifdef CESA_RECOVERY_EN
        chk("pin_ff_sum", {32'd0, e.s}, 64'h100);
`else
        chk("pin_ff_sum", {32'd0, e.s}, 64'h0);
`endif
        model(32'hFFFFFFFF, 32'h1, 1'b0, e);
`ifdef CESA_RECOVERY_EN
        chk("pin_wrap_sum", {32'd0, e.s}, 64'h0);
        chk("pin_wrap_cout", {63'd0, e.co}, 64'd1);
`else
        chk("pin_wrap_sum", {32'd0, e.s}, 64'hFFFFFF00);
        chk("pin_wrap_cout", {63'd0, e.co}, 64'd0);
`endif
        model(32'h5, 32'h7, 1'b0, e);
        chk("pin_57_sum", {32'd0, e.s}, 64'hC);

        repeat (3) tick();
        rst_ni = 1'b1;
        @(negedge clk);
        chk("rst_valid", {63'd0, out_valid_o}, 64'd0);
        chk("rst_sum", {32'd0, sum_o}, 64'd0);
        chk("rst_cout", {63'd0, cout_o}, 64'd0);
        chk("rst_err", {63'd0, spec_err_o}, 64'd0);
        chk("rst_ready", {63'd0, in_ready_o}, 64'd1);

        tick();
        send(32'h1, 32'h2, 1'b0);
        @(negedge clk);
        chk("t1_valid", {63'd0, out_valid_o}, 64'd1);
        chk("t1_sum", {32'd0, sum_o}, 64'h3);
        chk("t1_err", {63'd0, spec_err_o}, 64'd0);

        tick();
        send(32'hFF, 32'h1, 1'b0);
        @(negedge clk);
`ifdef CESA_RECOVERY_EN
        chk("t2_fix_valid", {63'd0, out_valid_o}, 64'd0);
        chk("t2_fix_ready", {63'd0, in_ready_o}, 64'd0);
        @(negedge clk);
        chk("t2_valid", {63'd0, out_valid_o}, 64'd1);
        chk("t2_sum", {32'd0, sum_o}, 64'h100);
`else
        chk("t2_valid", {63'd0, out_valid_o}, 64'd1);
        chk("t2_sum", {32'd0, sum_o}, 64'h0);
`endif
        chk("t2_err", {63'd0, spec_err_o}, 64'd1);

        tick();
        send(32'hFFFFFFFF, 32'h1, 1'b0);
        send(32'h5, 32'h7, 1'b0);
        @(negedge clk);
        chk("t4_valid", {63'd0, out_valid_o}, 64'd1);
        chk("t4_sum", {32'd0, sum_o}, 64'hC);
        chk("t4_err", {63'd0, spec_err_o}, 64'd0);

        tick();
        for (int i = 0; i < 5; i++) send(va[i], vb[i], vc[i]);
        repeat (3) tick();

        out_ready_i = 1'b0;
        send(32'h12345678, 32'h11111111, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_valid", {63'd0, out_valid_o}, 64'd1);
            chk("stall_sum", {32'd0, sum_o}, 64'h2345678A);
            chk("stall_ready", {63'd0, in_ready_o}, 64'd0);
        end
        tick();
        out_ready_i = 1'b1;
        @(negedge clk);
        chk("release_valid", {63'd0, out_valid_o}, 64'd1);
        tick();
        @(negedge clk);
        chk("after_xfer_valid", {63'd0, out_valid_o}, 64'd0);

        tick();
        send(32'hFF, 32'h1, 1'b0);
        rst_ni = 1'b0;
        tick();
        rst_ni = 1'b1;
        @(negedge clk);
        chk("rfix_valid", {63'd0, out_valid_o}, 64'd0);
        chk("rfix_sum", {32'd0, sum_o}, 64'd0);
        chk("rfix_cout", {63'd0, cout_o}, 64'd0);
        chk("rfix_err", {63'd0, spec_err_o}, 64'd0);
        chk("rfix_ready", {63'd0, in_ready_o}, 64'd1);
        repeat (4) begin
            @(negedge clk);
            chk("rfix_quiet", {63'd0, out_valid_o}, 64'd0);
        end

        tick();
        chk("drain", q.size(), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
